// File: rtl/cu_microsequencer.sv
// Microprogram sequencer: selects the next microstate address from the
// encoder, the control register or the incremented current address, with a
// single-level call/return register and a sticky sequencing-error flag.
//
// Next-address modes (n_sel), with ec = cond ^ inv:
//   000 enc_addr                 100 call: cr_addr, save inc
//   001 inc                      101 return: saved address (or RESET_ADDR + err)
//   010 ec ? cr_addr : inc       110 wait: ec ? inc : hold
//   011 ec ? cr_addr : enc_addr  111 hold
// stall freezes every register and outranks all modes.
module cu_microsequencer #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned RESET_ADDR = 0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              cond,
   input  logic              inv,
   input  logic [2:0]        n_sel,
   input  logic [ADDR_W-1:0] cr_addr,
   input  logic [ADDR_W-1:0] enc_addr,
   input  logic              stall,
   output logic [ADDR_W-1:0] state,
   output logic              ret_valid,
   output logic              err
);

   localparam logic [ADDR_W-1:0] L_RESET_ADDR = ADDR_W'(RESET_ADDR);
   localparam logic [ADDR_W-1:0] L_ONE        = ADDR_W'(1);

   typedef enum logic [2:0] {
      SEL_ENC    = 3'b000,
      SEL_INC    = 3'b001,
      SEL_BR_INC = 3'b010,
      SEL_BR_ENC = 3'b011,
      SEL_CALL   = 3'b100,
      SEL_RET    = 3'b101,
      SEL_WAIT   = 3'b110,
      SEL_HOLD   = 3'b111
   } sel_e;

   logic [ADDR_W-1:0] r_state;
   logic [ADDR_W-1:0] r_ret_addr;
   logic              r_ret_valid;
   logic              r_err;

   logic              w_ec;
   logic [ADDR_W-1:0] w_inc;
   logic [ADDR_W-1:0] w_state_nxt;
   logic [ADDR_W-1:0] w_ret_addr_nxt;
   logic              w_ret_valid_nxt;
   logic              w_err_nxt;

   assign w_ec  = cond ^ inv;
   assign w_inc = r_state + L_ONE;   // wraps naturally from all-ones to 0

   // Next-address selection and call/return bookkeeping for one microinstruction.
   always_comb begin
      w_state_nxt     = r_state;
      w_ret_addr_nxt  = r_ret_addr;
      w_ret_valid_nxt = r_ret_valid;
      w_err_nxt       = r_err;
      unique case (sel_e'(n_sel))
         SEL_ENC:    w_state_nxt = enc_addr;
         SEL_INC:    w_state_nxt = w_inc;
         SEL_BR_INC: w_state_nxt = w_ec ? cr_addr : w_inc;
         SEL_BR_ENC: w_state_nxt = w_ec ? cr_addr : enc_addr;
         SEL_CALL: begin
            // A second call overwrites the only return slot; flag the overflow.
            w_state_nxt     = cr_addr;
            w_ret_addr_nxt  = w_inc;
            w_ret_valid_nxt = 1'b1;
            if (r_ret_valid) w_err_nxt = 1'b1;
         end
         SEL_RET: begin
            if (r_ret_valid) begin
               w_state_nxt     = r_ret_addr;
               w_ret_valid_nxt = 1'b0;
            end else begin
               // Return with nothing saved: recover to the reset microstate.
               w_state_nxt = L_RESET_ADDR;
               w_err_nxt   = 1'b1;
            end
         end
         SEL_WAIT:   w_state_nxt = w_ec ? w_inc : r_state;
         SEL_HOLD:   w_state_nxt = r_state;
         default:    w_state_nxt = r_state;
      endcase
   end

   // Sequencer registers: async clear, frozen while stalled.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state     <= L_RESET_ADDR;
         r_ret_addr  <= '0;
         r_ret_valid <= 1'b0;
         r_err       <= 1'b0;
      end else if (!stall) begin
         r_state     <= w_state_nxt;
         r_ret_addr  <= w_ret_addr_nxt;
         r_ret_valid <= w_ret_valid_nxt;
         r_err       <= w_err_nxt;
      end
   end

   assign state     = r_state;
   assign ret_valid = r_ret_valid;
   assign err       = r_err;

endmodule

// File: tb/tb_cu_microsequencer.sv
// Directed bench for cu_microsequencer: a behavioural model predicts
// state/ret_valid/err per microinstruction, a compare process checks every
// cycle against an expected queue, and literal checks pin key scenarios.
module tb_cu_microsequencer;

   localparam int W = 10;  // {state[7:0], ret_valid, err}

   logic       clk;
   logic       clr;
   logic       cond;
   logic       inv;
   logic [2:0] n_sel;
   logic [7:0] cr_addr;
   logic [7:0] enc_addr;
   logic       stall;
   logic [7:0] state;
   logic       ret_valid;
   logic       err;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] exp_q[$];

   // model of the architectural state
   int m_state;
   int m_ret;
   bit m_rv;
   bit m_err;

   cu_microsequencer #(.ADDR_W(8), .RESET_ADDR(0)) dut (
      .clk      (clk),
      .clr      (clr),
      .cond     (cond),
      .inv      (inv),
      .n_sel    (n_sel),
      .cr_addr  (cr_addr),
      .enc_addr (enc_addr),
      .stall    (stall),
      .state    (state),
      .ret_valid(ret_valid),
      .err      (err)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // model: applies one microinstruction from the mode description
   task automatic model_step(input bit [2:0] ns, input bit c, input bit iv,
                             input int cr, input int en, input bit st);
      bit taken;
      int nxt;
      taken = (c != iv);
      nxt   = (m_state + 1) % 256;
      if (st) return;
      if (ns == 3'd0)      m_state = en;
      else if (ns == 3'd1) m_state = nxt;
      else if (ns == 3'd2) m_state = taken ? cr : nxt;
      else if (ns == 3'd3) m_state = taken ? cr : en;
      else if (ns == 3'd4) begin
         if (m_rv) m_err = 1;
         m_ret   = nxt;
         m_rv    = 1;
         m_state = cr;
      end else if (ns == 3'd5) begin
         if (m_rv) begin
            m_state = m_ret;
            m_rv    = 0;
         end else begin
            m_state = 0;
            m_err   = 1;
         end
      end else if (ns == 3'd6) begin
         if (taken) m_state = nxt;
      end
      // 3'd7: hold, nothing changes
   endtask

   function automatic logic [W-1:0] model_word();
      return {8'(m_state), 1'(m_rv), 1'(m_err)};
   endfunction

   // driver: one microinstruction per clock; idle edges use hold mode
   task automatic drive(input logic [2:0] ns, input logic c, input logic iv,
                        input logic [7:0] cr, input logic [7:0] en, input logic st);
      @(negedge clk);
      n_sel    = ns;
      cond     = c;
      inv      = iv;
      cr_addr  = cr;
      enc_addr = en;
      stall    = st;
      model_step(ns, c, iv, int'(cr), int'(en), st);
      @(posedge clk);
      #1;
      exp_q.push_back(model_word());
      n_sel = 3'b111;
      stall = 1'b0;
   endtask

   task automatic goto_addr(input logic [7:0] a);
      drive(3'b000, 1'b0, 1'b0, 8'h00, a, 1'b0);
   endtask

   // asynchronous clear pulse away from the clock edge
   task automatic pulse_clear(input string name);
      @(negedge clk);
      #2;
      clr = 1'b0;
      #1;
      m_state = 0; m_ret = 0; m_rv = 0; m_err = 0;
      check({name, "_state"}, 32'(state), 32'h00);
      check({name, "_rv"}, 32'(ret_valid), 32'h0);
      check({name, "_err"}, 32'(err), 32'h0);
      #1;
      clr = 1'b1;
   endtask

   // scoreboard compare: one expected word per driven microinstruction
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("cyc_state", 32'(state), 32'(e[9:2]));
         check("cyc_ret_valid", 32'(ret_valid), 32'(e[1]));
         check("cyc_err", 32'(err), 32'(e[0]));
      end
   end

   typedef struct {
      logic [2:0] ns;
      logic       c;
      logic       iv;
      logic [7:0] cr;
      logic [7:0] en;
      logic       st;
   } vec_t;

   initial begin
      vec_t tbl[12];
      clr = 1'b0; cond = 1'b0; inv = 1'b0; n_sel = 3'b111;
      cr_addr = 8'h00; enc_addr = 8'h00; stall = 1'b0;
      m_state = 0; m_ret = 0; m_rv = 0; m_err = 0;
      #12;
      check("rst_state", 32'(state), 32'h00);
      check("rst_rv", 32'(ret_valid), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      @(negedge clk);
      clr = 1'b1;

      // async clear from 0x12
      goto_addr(8'h12);
      check("r27_pre", 32'(state), 32'h12);
      pulse_clear("r27");

      // conditional branch vs increment
      goto_addr(8'h05);
      drive(3'b010, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0);
      check("r28_taken", 32'(state), 32'h40);
      goto_addr(8'h05);
      drive(3'b010, 1'b1, 1'b1, 8'h40, 8'h00, 1'b0);
      check("r28_inv", 32'(state), 32'h06);

      // call / return
      goto_addr(8'h10);
      drive(3'b100, 1'b0, 1'b0, 8'h80, 8'h00, 1'b0);
      check("r29_call_state", 32'(state), 32'h80);
      check("r29_call_rv", 32'(ret_valid), 32'h1);
      drive(3'b101, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      check("r29_ret_state", 32'(state), 32'h11);
      check("r29_ret_rv", 32'(ret_valid), 32'h0);
      check("r29_ret_err", 32'(err), 32'h0);

      // return underflow, err is sticky
      goto_addr(8'h33);
      drive(3'b101, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      check("r30_state", 32'(state), 32'h00);
      check("r30_err", 32'(err), 32'h1);
      for (int i = 0; i < 5; i++) drive(3'b001, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      check("r30_sticky_err", 32'(err), 32'h1);
      check("r30_sticky_state", 32'(state), 32'h05);
      pulse_clear("clr_err");

      // wait mode
      goto_addr(8'h20);
      for (int i = 0; i < 3; i++) drive(3'b110, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      check("r31_wait", 32'(state), 32'h20);
      drive(3'b110, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      check("r31_go", 32'(state), 32'h21);

      // wrap and stall
      goto_addr(8'hFF);
      drive(3'b001, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      check("r32_wrap", 32'(state), 32'h00);
      drive(3'b000, 1'b0, 1'b0, 8'h00, 8'h55, 1'b1);
      check("r32_stall", 32'(state), 32'h00);

      // call overflow still overwrites the return slot
      goto_addr(8'h08);
      drive(3'b100, 1'b0, 1'b0, 8'h30, 8'h00, 1'b0);
      drive(3'b100, 1'b0, 1'b0, 8'h60, 8'h00, 1'b0);
      check("ovf_state", 32'(state), 32'h60);
      check("ovf_err", 32'(err), 32'h1);
      drive(3'b101, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      check("ovf_ret", 32'(state), 32'h31);

      // clear mid-call drops the return context
      pulse_clear("midcall_pre");
      goto_addr(8'h44);
      drive(3'b100, 1'b0, 1'b0, 8'h90, 8'h00, 1'b0);
      pulse_clear("midcall");
      drive(3'b101, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      check("midcall_ret_state", 32'(state), 32'h00);
      check("midcall_ret_err", 32'(err), 32'h1);
      pulse_clear("tbl_pre");

      // mixed table: other modes, stall over call/return, hold, ec=0 branches
      tbl[0]  = '{3'b000, 1'b0, 1'b0, 8'h00, 8'h70, 1'b0};
      tbl[1]  = '{3'b011, 1'b0, 1'b0, 8'hA0, 8'h3C, 1'b0};
      tbl[2]  = '{3'b011, 1'b0, 1'b1, 8'hA0, 8'h3C, 1'b0};
      tbl[3]  = '{3'b010, 1'b1, 1'b1, 8'h11, 8'h00, 1'b0};
      tbl[4]  = '{3'b100, 1'b0, 1'b0, 8'hC0, 8'h00, 1'b1};
      tbl[5]  = '{3'b100, 1'b0, 1'b0, 8'hC0, 8'h00, 1'b0};
      tbl[6]  = '{3'b111, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
      tbl[7]  = '{3'b110, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
      tbl[8]  = '{3'b101, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
      tbl[9]  = '{3'b101, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
      tbl[10] = '{3'b001, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
      tbl[11] = '{3'b000, 1'b1, 1'b0, 8'h00, 8'hE7, 1'b0};
      foreach (tbl[i]) drive(tbl[i].ns, tbl[i].c, tbl[i].iv, tbl[i].cr, tbl[i].en, tbl[i].st);
      // 0x70 -> 0x3C -> 0xA0 -> 0xA1 -> (stall) -> call 0xC0 -> hold -> 0xC1
      // -> (stall) -> ret 0xA2 -> 0xA3 -> 0xE7
      check("tbl_model_pin", 32'(m_state), 32'hE7);
      check("tbl_state", 32'(state), 32'hE7);
      check("tbl_err", 32'(err), 32'h0);

      @(negedge clk);
      @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
